// File: rtl/tcdm_burst_rsp_sequencer.sv
// Orders per-lane TCDM responses by burst issue order; grouped bursts release all lanes at once.
// Response to out_valid takes at least 1 cycle; lanes stall via rsp_ready_o, the group handshake uses out_ready_i[0].
module tcdm_burst_rsp_sequencer #(
  parameter int unsigned RspGF         = 4,
  parameter int unsigned MaxBursts     = 4,
  parameter int unsigned TimeoutCycles = 16,
  parameter type         rsp_payload_t = logic
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           burst_valid_i,
  input  logic                           burst_group_i,
  output logic                           burst_ready_o,
  input  rsp_payload_t [RspGF-1:0]       rsp_payload_i,
  input  logic [RspGF-1:0]               rsp_valid_i,
  output logic [RspGF-1:0]               rsp_ready_o,
  output rsp_payload_t [RspGF-1:0]       out_payload_o,
  output logic [RspGF-1:0]               out_valid_o,
  input  logic [RspGF-1:0]               out_ready_i,
  output logic                           group_o,
  output logic                           timeout_o,
  output logic [$clog2(MaxBursts+1)-1:0] pending_o
);

  localparam int unsigned CW = $clog2(MaxBursts + 1);
  localparam int unsigned PW = (MaxBursts > 1) ? $clog2(MaxBursts) : 1;
  localparam int unsigned TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  if (RspGF < 2 || (RspGF & (RspGF - 1)) != 0) begin : g_bad_rspgf
    $error("RspGF must be a power of two greater than one");
  end
  if (MaxBursts < 1) begin : g_bad_maxbursts
    $error("MaxBursts must be at least one");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, GROUP_OUT, PASS} state_e;

  state_e                   state_q;
  logic [RspGF-1:0]         held_q, done_q;
  rsp_payload_t [RspGF-1:0] data_q;
  logic [MaxBursts-1:0]     grp_q;
  logic [PW-1:0]            rd_ptr_q, wr_ptr_q, rd_nxt, wr_nxt;
  logic [CW-1:0]            cnt_q;
  logic [TW-1:0]            to_cnt_q;
  logic                     timeout_q;

  logic [RspGF-1:0] acc, hs;
  logic             full, push, pop, all_in, next_vld, next_grp;
  state_e           next_head;

  assign full          = (cnt_q == CW'(MaxBursts));
  assign burst_ready_o = !full;
  assign push          = burst_valid_i & !full;
  assign rsp_ready_o   = (state_q != IDLE) ? ~(held_q | done_q) : '0;
  assign acc           = rsp_valid_i & rsp_ready_o;
  assign all_in        = &(held_q | acc);
  assign hs            = (state_q == PASS) ? (held_q & out_ready_i) : '0;
  assign rd_nxt        = (rd_ptr_q == PW'(MaxBursts - 1)) ? '0 : rd_ptr_q + PW'(1);
  assign wr_nxt        = (wr_ptr_q == PW'(MaxBursts - 1)) ? '0 : wr_ptr_q + PW'(1);

  // The entry pushed this cycle becomes head when the popped burst was the only one.
  assign next_vld  = (cnt_q > CW'(1)) | push;
  assign next_grp  = (cnt_q > CW'(1)) ? grp_q[rd_nxt] : burst_group_i;
  assign next_head = !next_vld ? IDLE : (next_grp ? COLLECT : PASS);

  always_comb begin
    pop         = 1'b0;
    out_valid_o = '0;
    unique case (state_q)
      GROUP_OUT: begin
        pop         = out_ready_i[0];
        out_valid_o = '1;
      end
      PASS: begin
        pop         = &(done_q | hs);
        out_valid_o = held_q;
      end
      default: begin
        pop         = 1'b0;
        out_valid_o = '0;
      end
    endcase
  end

  for (genvar i = 0; i < RspGF; i++) begin : g_out
    assign out_payload_o[i] = held_q[i] ? data_q[i] : rsp_payload_t'('0);
  end

  assign group_o   = (state_q == GROUP_OUT);
  assign timeout_o = timeout_q;
  assign pending_o = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      held_q    <= '0;
      done_q    <= '0;
      data_q    <= '0;
      grp_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (push) begin
        grp_q[wr_ptr_q] <= burst_group_i;
        wr_ptr_q        <= wr_nxt;
      end
      if (pop) rd_ptr_q <= rd_nxt;
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      for (int i = 0; i < RspGF; i++) begin
        if (acc[i]) data_q[i] <= rsp_payload_i[i];
      end

      unique case (state_q)
        IDLE: begin
          if (push) state_q <= burst_group_i ? COLLECT : PASS;
        end
        COLLECT: begin
          held_q <= held_q | acc;
          // A last lane landing on the timeout cycle still wins the grouped release.
          if (all_in) begin
            state_q  <= GROUP_OUT;
            to_cnt_q <= '0;
          end else if ((TimeoutCycles > 0) && (to_cnt_q == TW'(TimeoutCycles - 1))) begin
            state_q   <= PASS;
            timeout_q <= 1'b1;
            to_cnt_q  <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        GROUP_OUT: begin
          if (pop) begin
            held_q   <= '0;
            done_q   <= '0;
            to_cnt_q <= '0;
            state_q  <= next_head;
          end
        end
        PASS: begin
          if (pop) begin
            held_q   <= '0;
            done_q   <= '0;
            to_cnt_q <= '0;
            state_q  <= next_head;
          end else begin
            held_q <= (held_q & ~hs) | acc;
            done_q <= done_q | hs;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcdm_burst_rsp_sequencer.sv
// Directed bench for tcdm_burst_rsp_sequencer: grouped, ungrouped, timeout, full tracker, stall, reset.
module tb_tcdm_burst_rsp_sequencer;
  localparam int GF = 4;
  typedef logic [7:0] pl_t;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           burst_valid_i = 1'b0;
  logic           burst_group_i = 1'b0;
  logic           burst_ready_o;
  pl_t [GF-1:0]   rsp_payload_i = '0;
  logic [GF-1:0]  rsp_valid_i = '0;
  logic [GF-1:0]  rsp_ready_o;
  pl_t [GF-1:0]   out_payload_o;
  logic [GF-1:0]  out_valid_o;
  logic [GF-1:0]  out_ready_i = '0;
  logic           group_o;
  logic           timeout_o;
  logic [2:0]     pending_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  tcdm_burst_rsp_sequencer #(
    .RspGF(GF), .MaxBursts(4), .TimeoutCycles(16), .rsp_payload_t(pl_t)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .burst_valid_i(burst_valid_i), .burst_group_i(burst_group_i), .burst_ready_o(burst_ready_o),
    .rsp_payload_i(rsp_payload_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .out_payload_o(out_payload_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .group_o(group_o), .timeout_o(timeout_o), .pending_o(pending_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid_o), 32'h0);
    check_eq({tag, "_rsp_ready"}, 32'(rsp_ready_o), 32'h0);
    check_eq({tag, "_group"}, 32'(group_o), 32'h0);
    check_eq({tag, "_timeout"}, 32'(timeout_o), 32'h0);
    check_eq({tag, "_pending"}, 32'(pending_o), 32'h0);
    check_eq({tag, "_burst_ready"}, 32'(burst_ready_o), 32'h1);
    check_eq({tag, "_payload"}, 32'(out_payload_o), 32'h0);
  endtask

  // Present all four lanes in one cycle, then expect a full release the next cycle.
  task automatic drain_one(input logic grp, input int exp_pend, input logic [7:0] base,
                           input logic push_try);
    logic [31:0] exp_pl;
    for (int l = 0; l < GF; l++) begin
      rsp_payload_i[l]    = base + 8'(l);
      exp_pl[l*8 +: 8]    = base + 8'(l);
    end
    rsp_valid_i = '1;
    out_ready_i = '0;
    tick();
    rsp_valid_i   = '0;
    out_ready_i   = '1;
    burst_valid_i = push_try;
    burst_group_i = 1'b0;
    #1;
    check_eq("drain_out_valid", 32'(out_valid_o), 32'hF);
    check_eq("drain_group", 32'(group_o), 32'(grp));
    check_eq("drain_pending", 32'(pending_o), 32'(exp_pend));
    check_eq("drain_payload", 32'(out_payload_o), exp_pl);
    tick();
    burst_valid_i = 1'b0;
    out_ready_i   = '0;
  endtask

  initial begin
    logic [3:0] fl;

    // Reset values
    tick();
    tick();
    check_idle_outputs("rst");
    rst_i = 1'b0;
    tick();

    // Grouped burst: lanes 0,1 in cycle 1, lane 3 in cycle 2, lane 2 in cycle 3
    burst_valid_i = 1'b1;
    burst_group_i = 1'b1;
    #1;
    check_eq("g_burst_ready", 32'(burst_ready_o), 32'h1);
    tick();
    burst_valid_i = 1'b0;
    rsp_valid_i   = 4'b0011;
    rsp_payload_i = {8'h00, 8'h00, 8'hA1, 8'hA0};
    #1;
    check_eq("g_pending1", 32'(pending_o), 32'h1);
    check_eq("g_rsp_ready_c1", 32'(rsp_ready_o), 32'hF);
    check_eq("g_out_valid_c1", 32'(out_valid_o), 32'h0);
    tick();
    rsp_valid_i   = 4'b1000;
    rsp_payload_i = {8'hA3, 8'h00, 8'h00, 8'h00};
    #1;
    check_eq("g_rsp_ready_c2", 32'(rsp_ready_o), 32'hC);
    tick();
    rsp_valid_i   = 4'b0100;
    rsp_payload_i = {8'h00, 8'hA2, 8'h00, 8'h00};
    #1;
    check_eq("g_out_valid_c3", 32'(out_valid_o), 32'h0);
    tick();
    rsp_valid_i = '0;
    out_ready_i = '1;
    #1;
    check_eq("g_out_valid_c4", 32'(out_valid_o), 32'hF);
    check_eq("g_group_c4", 32'(group_o), 32'h1);
    check_eq("g_payload_c4", 32'(out_payload_o), 32'hA3A2A1A0);
    tick();
    out_ready_i = '0;
    #1;
    check_eq("g_out_valid_c5", 32'(out_valid_o), 32'h0);
    check_eq("g_group_c5", 32'(group_o), 32'h0);
    check_eq("g_pending_c5", 32'(pending_o), 32'h0);

    // Ungrouped burst: one lane per cycle, each released the cycle after accept
    burst_valid_i = 1'b1;
    burst_group_i = 1'b0;
    tick();
    burst_valid_i = 1'b0;
    out_ready_i   = '1;
    rsp_valid_i   = 4'b0001;
    rsp_payload_i = {8'h00, 8'h00, 8'h00, 8'hB0};
    #1;
    check_eq("u_out_valid_c1", 32'(out_valid_o), 32'h0);
    tick();
    rsp_valid_i   = 4'b0010;
    rsp_payload_i = {8'h00, 8'h00, 8'hB1, 8'h00};
    #1;
    check_eq("u_out_valid_c2", 32'(out_valid_o), 32'h1);
    check_eq("u_payload_c2", 32'(out_payload_o), 32'h000000B0);
    check_eq("u_group_c2", 32'(group_o), 32'h0);
    tick();
    rsp_valid_i   = 4'b0100;
    rsp_payload_i = {8'h00, 8'hB2, 8'h00, 8'h00};
    #1;
    check_eq("u_out_valid_c3", 32'(out_valid_o), 32'h2);
    check_eq("u_payload_c3", 32'(out_payload_o), 32'h0000B100);
    tick();
    rsp_valid_i   = 4'b1000;
    rsp_payload_i = {8'hB3, 8'h00, 8'h00, 8'h00};
    #1;
    check_eq("u_out_valid_c4", 32'(out_valid_o), 32'h4);
    check_eq("u_rsp_ready_c4", 32'(rsp_ready_o), 32'h8);
    tick();
    rsp_valid_i = '0;
    #1;
    check_eq("u_out_valid_c5", 32'(out_valid_o), 32'h8);
    check_eq("u_group_c5", 32'(group_o), 32'h0);
    check_eq("u_pending_c5", 32'(pending_o), 32'h1);
    tick();
    out_ready_i = '0;
    #1;
    check_eq("u_pending_c6", 32'(pending_o), 32'h0);
    check_eq("u_out_valid_c6", 32'(out_valid_o), 32'h0);

    // Grouped burst with lane 2 missing: watchdog falls back to individual release
    burst_valid_i = 1'b1;
    burst_group_i = 1'b1;
    tick();
    burst_valid_i = 1'b0;
    rsp_valid_i   = 4'b1011;
    rsp_payload_i = {8'hC3, 8'h00, 8'hC1, 8'hC0};
    tick();
    rsp_valid_i = '0;
    repeat (14) tick();
    #1;
    check_eq("to_timeout_c16", 32'(timeout_o), 32'h0);
    check_eq("to_out_valid_c16", 32'(out_valid_o), 32'h0);
    tick();
    out_ready_i = 4'b1011;
    #1;
    check_eq("to_timeout_c17", 32'(timeout_o), 32'h1);
    check_eq("to_out_valid_c17", 32'(out_valid_o), 32'hB);
    check_eq("to_payload_c17", 32'(out_payload_o), 32'hC300C1C0);
    check_eq("to_group_c17", 32'(group_o), 32'h0);
    tick();
    out_ready_i   = '0;
    rsp_valid_i   = 4'b0100;
    rsp_payload_i = {8'h00, 8'hC2, 8'h00, 8'h00};
    #1;
    check_eq("to_timeout_c18", 32'(timeout_o), 32'h0);
    check_eq("to_out_valid_c18", 32'(out_valid_o), 32'h0);
    check_eq("to_rsp_ready_c18", 32'(rsp_ready_o), 32'h4);
    check_eq("to_pending_c18", 32'(pending_o), 32'h1);
    tick();
    rsp_valid_i = '0;
    out_ready_i = 4'b0100;
    #1;
    check_eq("to_out_valid_c19", 32'(out_valid_o), 32'h4);
    check_eq("to_payload_c19", 32'(out_payload_o), 32'h00C20000);
    tick();
    out_ready_i = '0;
    #1;
    check_eq("to_pending_c20", 32'(pending_o), 32'h0);
    check_eq("to_out_valid_c20", 32'(out_valid_o), 32'h0);

    // Fill the tracker, try a push while full, then drain in order
    fl = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      burst_valid_i = 1'b1;
      burst_group_i = fl[b];
      #1;
      check_eq("full_ready_before_push", 32'(burst_ready_o), 32'h1);
      tick();
    end
    burst_valid_i = 1'b1;
    burst_group_i = 1'b1;
    #1;
    check_eq("full_ready", 32'(burst_ready_o), 32'h0);
    check_eq("full_pending", 32'(pending_o), 32'h4);
    tick();
    burst_valid_i = 1'b0;
    #1;
    check_eq("full_pending_after_try", 32'(pending_o), 32'h4);
    for (int b = 0; b < 4; b++) begin
      drain_one(fl[b], 4 - b, 8'h40 + 8'(16 * b), (b == 0));
    end
    #1;
    check_eq("full_pending_drained", 32'(pending_o), 32'h0);
    check_eq("full_out_valid_drained", 32'(out_valid_o), 32'h0);

    // Stalled GROUP_OUT: only out_ready_i[0] counts; push/pop in one cycle keeps the count
    burst_valid_i = 1'b1;
    burst_group_i = 1'b1;
    tick();
    burst_valid_i = 1'b0;
    rsp_valid_i   = '1;
    rsp_payload_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    tick();
    rsp_valid_i   = '0;
    out_ready_i   = 4'b1110;
    burst_valid_i = 1'b1;
    burst_group_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check_eq("stall_out_valid", 32'(out_valid_o), 32'hF);
      check_eq("stall_group", 32'(group_o), 32'h1);
      check_eq("stall_payload", 32'(out_payload_o), 32'hD3D2D1D0);
      check_eq("stall_rsp_ready", 32'(rsp_ready_o), 32'h0);
      check_eq("stall_pending", 32'(pending_o), (s == 0) ? 32'h1 : 32'h2);
      tick();
      burst_valid_i = 1'b0;
    end
    out_ready_i   = 4'b0001;
    burst_valid_i = 1'b1;
    burst_group_i = 1'b1;
    #1;
    check_eq("stall_release_valid", 32'(out_valid_o), 32'hF);
    tick();
    burst_valid_i = 1'b0;
    out_ready_i   = '0;
    #1;
    check_eq("stall_pending_pushpop", 32'(pending_o), 32'h2);
    check_eq("stall_next_group", 32'(group_o), 32'h0);
    check_eq("stall_next_out_valid", 32'(out_valid_o), 32'h0);
    check_eq("stall_next_rsp_ready", 32'(rsp_ready_o), 32'hF);
    drain_one(1'b0, 2, 8'h60, 1'b0);
    drain_one(1'b1, 1, 8'h68, 1'b0);
    #1;
    check_eq("stall_pending_drained", 32'(pending_o), 32'h0);

    // Reset while two lanes are held in COLLECT
    burst_valid_i = 1'b1;
    burst_group_i = 1'b1;
    tick();
    burst_valid_i = 1'b0;
    rsp_valid_i   = 4'b0101;
    rsp_payload_i = {8'h00, 8'h92, 8'h00, 8'h90};
    tick();
    rsp_valid_i = '0;
    #1;
    check_eq("mid_rsp_ready_held", 32'(rsp_ready_o), 32'hA);
    rst_i = 1'b1;
    tick();
    check_idle_outputs("mid_rst");
    rst_i = 1'b0;
    tick();
    burst_valid_i = 1'b1;
    burst_group_i = 1'b1;
    tick();
    burst_valid_i = 1'b0;
    #1;
    check_eq("post_rst_rsp_ready", 32'(rsp_ready_o), 32'hF);
    drain_one(1'b1, 1, 8'h70, 1'b0);
    #1;
    check_eq("post_rst_pending", 32'(pending_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
